// File: rtl/multiplier_arbiter_pkg.sv
// rtl/multiplier_arbiter_pkg.sv - shared state encoding and datapath widths for multiplier_arbiter
package multiplier_arbiter_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/multiplier_arbiter_rr_arbiter.sv
// rtl/multiplier_arbiter_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr_i, wrapping
module multiplier_arbiter_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             vld_o
);

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// rtl/multiplier_arbiter.sv - shares one multiplier_32 among N_REQ requesters, round-robin
// Optional dne watchdog with sticky err: define MUL_ARB_TIMEOUT_EN.
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ*OP_W-1:0] req_a_i,
  input  logic [N_REQ*OP_W-1:0] req_b_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic                  rsp_vld_o,
  input  logic                  rsp_rdy_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [PROD_W-1:0]     rsp_p_o,
  output logic                  busy_o,
  output logic [OP_W-1:0]       mul_a_o,
  output logic [OP_W-1:0]       mul_b_o,
  output logic                  mul_start_o,
  output logic                  mul_ena_o,
  input  logic [PROD_W-1:0]     mul_p_i,
  input  logic                  mul_dne_i,
  output logic                  err_o
);

  if (N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ) || TIMEOUT < 1) begin : g_param_chk
    $error("multiplier_arbiter: unsupported parameter set");
  end

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [OP_W-1:0]     mul_a_q, mul_b_q;
  logic [PROD_W-1:0]   rsp_p_q;
  logic [N_REQ-1:0]    arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_vld;
  logic                take;
  logic                finish;
  logic                tmo;

  multiplier_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign take   = (state_q == ST_IDLE) && arb_vld;
  assign finish = (state_q == ST_BUSY) && (mul_dne_i || tmo);

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // cnt_q counts completed BUSY cycles; the last allowed one is TIMEOUT-1
  assign tmo = (state_q == ST_BUSY) && !mul_dne_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ST_START) begin
        cnt_q <= '0;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // mul_dne is not looked at in START: it may still be high from the previous product
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_vld) state_d = ST_START;
      ST_START: state_d = ST_BUSY;
      ST_BUSY:  if (finish) state_d = ST_DONE;
      ST_DONE:  if (rsp_rdy_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o       = '0;
    mul_ena_o   = rst_ni;
    busy_o      = (state_q != ST_IDLE);
    mul_start_o = (state_q == ST_START);
    rsp_vld_o   = (state_q == ST_DONE);
    if (rst_ni && state_q == ST_IDLE) begin
      gnt_o = arb_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      rsp_id_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      rsp_p_q  <= '0;
    end else begin
      if (take) begin
        mul_a_q  <= req_a_i[OP_W*arb_idx +: OP_W];
        mul_b_q  <= req_b_i[OP_W*arb_idx +: OP_W];
        rsp_id_q <= arb_idx;
        ptr_q    <= (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
      end
      if (finish) begin
        rsp_p_q <= mul_dne_i ? mul_p_i : '0;
      end
    end
  end

  assign mul_a_o  = mul_a_q;
  assign mul_b_o  = mul_b_q;
  assign rsp_id_o = rsp_id_q;
  assign rsp_p_o  = rsp_p_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb/tb_multiplier_arbiter.sv - randomized self-checking bench for multiplier_arbiter with a transaction-level model
module tb_multiplier_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic            rsp_rdy = 1'b0;
  logic [N-1:0]    gnt;
  logic            rsp_vld;
  logic [IDW-1:0]  rsp_id;
  logic [63:0]     rsp_p;
  logic            busy;
  logic [31:0]     mul_a, mul_b;
  logic            mul_start, mul_ena;
  logic [63:0]     mp;
  logic            mdne;
  logic            err;

  always #5 clk = ~clk;

  multiplier_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_a_i(req_a), .req_b_i(req_b),
    .gnt_o(gnt), .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_id_o(rsp_id),
    .rsp_p_o(rsp_p), .busy_o(busy), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_start_o(mul_start), .mul_ena_o(mul_ena), .mul_p_i(mp), .mul_dne_i(mdne),
    .err_o(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
  endfunction

  // Behavioural multiplier: start pulse clears dne, product appears lat cycles later
  int   lat = 3;
  bit   dne_stuck = 1'b0;
  int   mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdne <= 1'b0; mcnt <= 0; mp <= '0;
    end else if (mul_start) begin
      mdne <= 1'b0; mcnt <= lat;
    end else if (mcnt == 1 && !dne_stuck) begin
      mdne <= 1'b1; mp <= smul(mul_a, mul_b); mcnt <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: at most one operation in flight, fair rotation from mptr
  bit           mon_en = 1'b0;
  bit           outst, dne_seen, prev_hold;
  int           mptr, g_cyc, cur_id, n_done, w, j;
  logic [31:0]  cur_a, cur_b;
  logic [63:0]  cur_p, prev_p;
  logic [IDW-1:0] prev_id;
  logic [N-1:0] exp_g, last_g;

  task automatic model_reset();
    outst = 1'b0; dne_seen = 1'b0; prev_hold = 1'b0; mptr = 0;
  endtask

  always @(negedge clk) begin
    last_g = gnt;
    if (mon_en && rst_n) begin
      exp_g = '0;
      w = -1;
      if (!outst) begin
        for (int k = 0; k < N; k++) begin
          j = (mptr + k) % N;
          if (w < 0 && req[j]) begin
            w = j;
            exp_g[j] = 1'b1;
          end
        end
      end
      chk(gnt == exp_g, "gnt", gnt, exp_g);
      chk(busy == outst, "busy", busy, outst);
      chk(mul_start == (outst && cyc == g_cyc + 1), "mul_start", mul_start, outst && cyc == g_cyc + 1);
      chk(rsp_vld == (outst && dne_seen), "rsp_vld", rsp_vld, outst && dne_seen);
      chk(mul_ena == 1'b1, "mul_ena", mul_ena, 1);
      chk(err == 1'b0, "err", err, 0);
      if (outst && cyc > g_cyc)
        chk({mul_a, mul_b} == {cur_a, cur_b}, "mul_ops", {mul_a, mul_b}, {cur_a, cur_b});
      if (prev_hold) begin
        chk(rsp_p == prev_p, "hold_p", rsp_p, prev_p);
        chk(rsp_id == prev_id, "hold_id", rsp_id, prev_id);
      end
      if (outst && rsp_vld && rsp_rdy) begin
        chk(rsp_id == IDW'(cur_id), "rsp_id", rsp_id, cur_id);
        chk(rsp_p == cur_p, "rsp_p", rsp_p, cur_p);
        outst = 1'b0; dne_seen = 1'b0; n_done++;
      end
      prev_hold = rsp_vld && !rsp_rdy;
      prev_p    = cur_p;
      prev_id   = IDW'(cur_id);
      if (outst && cyc >= g_cyc + 2 && mdne) dne_seen = 1'b1;
      if (w >= 0) begin
        outst = 1'b1; g_cyc = cyc; cur_id = w;
        cur_a = req_a[32*w +: 32]; cur_b = req_b[32*w +: 32];
        cur_p = smul(cur_a, cur_b);
        mptr  = (w + 1) % N;
      end
    end
  end

  bit hold_all = 1'b0;
  bit rnd_mode = 1'b0;

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold_all) req = req & ~last_g;
    if (rnd_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_a[32*i +: 32] = rnd_op();
            req_b[32*i +: 32] = rnd_op();
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      rsp_rdy = ($urandom_range(0, 2) != 0);
      lat = $urandom_range(1, 6);
    end
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (gnt != 0) begin
        g = gnt;
        break;
      end
    end
    if (g == 0) chk(1'b0, "gnt_timeout", 0, 1);
  endtask

  task automatic wait_vld();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_vld) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(1'b0, "vld_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(gnt == 0, {nm, "_gnt"}, gnt, 0);
    chk(rsp_vld == 0, {nm, "_rsp_vld"}, rsp_vld, 0);
    chk(rsp_id == 0, {nm, "_rsp_id"}, rsp_id, 0);
    chk(rsp_p == 0, {nm, "_rsp_p"}, rsp_p, 0);
    chk(busy == 0, {nm, "_busy"}, busy, 0);
    chk(mul_a == 0 && mul_b == 0, {nm, "_mul_ops"}, {mul_a, mul_b}, 0);
    chk(mul_start == 0, {nm, "_mul_start"}, mul_start, 0);
    chk(mul_ena == 0, {nm, "_mul_ena"}, mul_ena, 0);
    chk(err == 0, {nm, "_err"}, err, 0);
  endtask

  logic [N-1:0] g;
  int base, gc;

  initial begin
    req = 4'hF;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    req = '0; rst_n = 1'b1; rsp_rdy = 1'b1; model_reset(); mon_en = 1'b1;

    // all requesters held high: rotation 0,1,2,3,0
    hold_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h7FFF_FFFF;
      req_b[32*i +: 32] = 32'h7FFF_FFFF;
    end
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(g);
      chk(g == (4'b0001 << (n % 4)), "rr_order", g, 4'b0001 << (n % 4));
      wait_vld();
      chk(rsp_id == IDW'(n % 4), "rr_id", rsp_id, n % 4);
      chk(rsp_p == 64'h3FFF_FFFF_0000_0001, "rr_p", rsp_p, 64'h3FFF_FFFF_0000_0001);
    end
    @(posedge clk); #1;
    req = '0; hold_all = 1'b0;

    // single requester: -7 * 6
    req_a[31:0] = 32'hFFFF_FFF9; req_b[31:0] = 32'd6; req = 4'b0001;
    wait_gnt(g);
    chk(g == 4'b0001, "single_gnt", g, 4'b0001);
    tick();
    wait_vld();
    chk(rsp_id == 0, "single_id", rsp_id, 0);
    chk(rsp_p == 64'hFFFF_FFFF_FFFF_FFD6, "single_p", rsp_p, 64'hFFFF_FFFF_FFFF_FFD6);

    // backpressure: 123 * -5 held for 10 cycles while requester 3 waits
    tick();
    rsp_rdy = 1'b0;
    req_a[95:64] = 32'd123; req_b[95:64] = 32'hFFFF_FFFB;
    req_a[127:96] = 32'd9;  req_b[127:96] = 32'd10;
    req = 4'b1100;
    wait_gnt(g);
    chk(g == 4'b0100, "bp_gnt", g, 4'b0100);
    tick();
    wait_vld();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(rsp_vld == 1'b1, "bp_vld", rsp_vld, 1);
      chk(rsp_p == 64'hFFFF_FFFF_FFFF_FD99, "bp_p", rsp_p, 64'hFFFF_FFFF_FFFF_FD99);
      chk(rsp_id == 2, "bp_id", rsp_id, 2);
      chk(gnt == 0 && mul_start == 0, "bp_quiet", {gnt, mul_start}, 0);
    end
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    wait_gnt(g);
    chk(g == 4'b1000, "bp_next_gnt", g, 4'b1000);
    tick();
    wait_vld();
    chk(rsp_p == 64'd90, "bp_next_p", rsp_p, 64'd90);

    // edge operands
    tick();
    req_a[31:0] = 32'h8000_0000; req_b[31:0] = 32'h8000_0000; req = 4'b0001;
    wait_gnt(g);
    tick();
    wait_vld();
    chk(rsp_p == 64'h4000_0000_0000_0000, "edge_min_min", rsp_p, 64'h4000_0000_0000_0000);
    tick();
    req_a[63:32] = 32'hFFFF_FFFF; req_b[63:32] = 32'd1; req = 4'b0010;
    wait_gnt(g);
    chk(g == 4'b0010, "edge_gnt", g, 4'b0010);
    tick();
    wait_vld();
    chk(rsp_p == 64'hFFFF_FFFF_FFFF_FFFF, "edge_m1", rsp_p, 64'hFFFF_FFFF_FFFF_FFFF);
    chk(rsp_id == 1, "edge_id", rsp_id, 1);

    // reset while BUSY, then rotation restarts at requester 0
    tick();
    dne_stuck = 1'b1;
    req_a[63:32] = 32'd5; req_b[63:32] = 32'd7; req = 4'b0010;
    wait_gnt(g);
    tick();
    repeat (3) @(negedge clk);
    chk(busy == 1'b1, "busy_before_abort", busy, 1);
    mon_en = 1'b0;
    #2;
    req = 4'hF;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1; dne_stuck = 1'b0; model_reset(); mon_en = 1'b1;
    wait_gnt(g);
    chk(g == 4'b0001, "ptr_after_reset", g, 4'b0001);
    tick();
    req = '0;
    wait_vld();

    // randomized traffic
    tick();
    base = n_done;
    rnd_mode = 1'b1;
    for (int i = 0; i < 8000 && (n_done - base) < 200; i++) tick();
    rnd_mode = 1'b0;
    req = '0; rsp_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(busy == 1'b0, "drain", busy, 0);
    chk((n_done - base) >= 200, "random_ops", n_done - base, 200);

`ifdef MUL_ARB_TIMEOUT_EN
    tick();
    mon_en = 1'b0;
    dne_stuck = 1'b1;
    req_a[31:0] = 32'd3; req_b[31:0] = 32'd4; req = 4'b0001;
    wait_gnt(g);
    gc = cyc;
    tick();
    wait_vld();
    chk(cyc - gc == TO + 2, "tmo_latency", cyc - gc, TO + 2);
    chk(err == 1'b1, "tmo_err", err, 1);
    chk(rsp_p == 0, "tmo_p", rsp_p, 0);
    @(negedge clk);
    chk(err == 1'b1, "tmo_err_sticky", err, 1);
    chk(rsp_vld == 1'b0, "tmo_vld_clear", rsp_vld, 0);
    rst_n = 1'b0;
    #1;
    chk(err == 1'b0, "tmo_err_reset", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; dne_stuck = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
